sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/div_pkg.sv | 5 +
 rtl/div_step.sv | 20 ++
 rtl/sequential_divider.sv | 81 ++++++++
 tb/tb_sequential_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared width default and FSM state encoding for the divider
package div_pkg;
    localparam int WIDTH_DEFAULT = 32;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift, compare, conditional subtract)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH+1:0] wide;
    logic             ge;
    // shift the next dividend bit into the remainder and subtract when it fits
    always_comb begin
        wide    = {rem_in, quo_in[WIDTH-1]};
        ge      = wide >= {2'b00, den};
        rem_out = (WIDTH+1)'(ge ? wide - {2'b00, den} : wide);
        quo_out = {quo_in[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/sequential_divider.sv
// sequential_divider: signed restoring divider, one bit per cycle, fixed WIDTH+1 latency
module sequential_divider
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next, den_mag;
    logic             q_neg, r_neg, zero;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in (rem_reg),
        .quo_in (quo_reg),
        .den    (den_mag),
        .rem_out(rem_next),
        .quo_out(quo_next)
    );

    // next state: accept in IDLE, iterate WIDTH times, one FINISH cycle to publish
    always_comb begin
        state_next = state == IDLE ? (start ? RUN : IDLE)
                   : state == RUN  ? (count == CW'(WIDTH - 1) ? FINISH : RUN)
                   : IDLE;
        busy       = state != IDLE;
    end

    // datapath and result registers; operands are only captured when IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            den_mag     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zero        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_next;
            done  <= state == FINISH;
            if (state == IDLE && start) begin
                quo_reg <= dividend[WIDTH-1] ? -dividend : dividend;
                den_mag <= divisor[WIDTH-1] ? -divisor : divisor;
                q_neg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_neg   <= dividend[WIDTH-1];
                zero    <= divisor == '0;
                rem_reg <= '0;
                count   <= '0;
            end
            if (state == RUN) begin
                rem_reg <= rem_next;
                quo_reg <= quo_next;
                count   <= count + 1'b1;
            end
            if (state == FINISH) begin
                quotient    <= zero ? '1 : q_neg ? -quo_reg : quo_reg;
                remainder   <= r_neg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
                div_by_zero <= zero;
            end
        end
    end
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: directed checks of latency, signs, divide-by-zero, overflow, back-to-back and reset abort
module tb_sequential_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    int          checks = 0;
    int          errors = 0;

    sequential_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Called at a negedge with the divider idle. Returns at the negedge of the done cycle;
    // lat counts rising edges from the accepting edge to the one raising done (-1 on timeout).
    // glitch_at > 0 pulses start with 9 / 2 after that many RUN edges.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int glitch_at,
                          output int lat, output logic busy_after_accept);
        lat = -1;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_after_accept = busy;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            start = n == glitch_at;
            if (n == glitch_at) begin
                dividend = 32'd9;
                divisor = 32'd2;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dz=%b, want all zero", busy, done, quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int   lat;
        logic b0;
        run_op(32'd100, 32'd7, 0, lat, b0);
        checks++;
        if (b0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b after accept, want 1", b0);
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, want 33", lat);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_100_7: q=%h r=%h dz=%b, want 0000000e 00000002 0", quotient, remainder, div_by_zero);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done: busy=%b in done cycle, want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL basic_pulse_hold: done=%b q=%h r=%h, want 0 0000000e 00000002", done, quotient, remainder);
        end
    endtask

    task automatic test_signs_and_edges;
        logic [31:0] ta [6] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'd5, 32'hFFFFFFFB, 32'h80000000};
        logic [31:0] tb [6] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] tq [6] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] tr [6] = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE, 32'd5, 32'hFFFFFFFB, 32'd0};
        logic        tz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int          lat;
        logic        b0;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], 0, lat, b0);
            checks++;
            if (lat !== 33 || quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== tz[i]) begin
                errors++;
                $display("FAIL vec%0d_%h_div_%h: lat=%0d q=%h r=%h dz=%b, want 33 %h %h %b",
                         i, ta[i], tb[i], lat, quotient, remainder, div_by_zero, tq[i], tr[i], tz[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int   lat;
        logic b0;
        run_op(32'd100, 32'd7, 5, lat, b0);
        checks++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL ignore_busy_start: lat=%0d q=%h r=%h, want 33 0000000e 00000002", lat, quotient, remainder);
        end
        run_op(32'd9, 32'd2, 0, lat, b0);
        checks++;
        if (lat !== 33 || quotient !== 32'd4 || remainder !== 32'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_9_2: lat=%0d q=%h r=%h dz=%b, want 33 00000004 00000001 0", lat, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int   lat;
        logic b0;
        logic seen = 1'b0;
        dividend = 32'd100;
        divisor = 32'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b q=%h r=%h dz=%b, want all zero", busy, done, quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: activity=%b after abort, want 0", seen);
        end
        run_op(32'd100, 32'd7, 0, lat, b0);
        checks++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL after_abort_100_7: lat=%0d q=%h r=%h dz=%b, want 33 0000000e 00000002 0", lat, quotient, remainder, div_by_zero);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signs_and_edges;
        test_back_to_back;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
